// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
//
// Shared definitions for the instruction-fetch sequencer and its helpers:
//   - default reset vector / IM depth and the derived index width and limit
//   - FSM state encoding (BOOT, RUN, FAULT)
//   - im_limit(): exclusive upper bound of the IM address window, computed
//     in 33 bits so a window touching the top of the address space does not
//     wrap to zero.
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam logic [31:0] DEF_PC_RESET  = 32'h0000_3000;
    localparam int          DEF_IM_WORDS  = 4096;
    localparam int          DEF_IM_ADDR_W = $clog2(DEF_IM_WORDS);

    // Sequencer state encoding
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t ST_BOOT  = 2'd0;
    localparam fetch_state_t ST_RUN   = 2'd1;
    localparam fetch_state_t ST_FAULT = 2'd2;

    function automatic logic [32:0] im_limit(input logic [31:0] base, input int words);
        return {1'b0, base} + (33'(words) << 2);
    endfunction

    localparam logic [32:0] DEF_IM_LIMIT = im_limit(DEF_PC_RESET, DEF_IM_WORDS);

endpackage

// File: rtl/pc_range_check.sv
// ---------------------------------------------------------------------------
// pc_range_check
//
// Combinational translation of a byte fetch address into an IM word index,
// plus a legality flag for that address.
//
// Ports:
//   pc        in   32         fetch byte address
//   im_index  out  IM_ADDR_W  (pc - PC_RESET) >> 2, wraps modulo IM_WORDS
//   pc_ok     out  1          address is inside the IM window and aligned
//
// Build option: FETCH_FAULT_EN
//   defined     -> pc_ok = PC_RESET <= pc < PC_RESET + 4*IM_WORDS, pc[1:0]==0
//   not defined -> pc_ok is always 1 (index simply wraps)
// ---------------------------------------------------------------------------
module pc_range_check
    import fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = DEF_PC_RESET,
    parameter int          IM_WORDS  = DEF_IM_WORDS,
    localparam int         IM_ADDR_W = $clog2(IM_WORDS)
) (
    input  logic [31:0]          pc,
    output logic [IM_ADDR_W-1:0] im_index,
    output logic                 pc_ok
);

    logic [31:0] offset;

    // Subtraction wraps mod 2^32, so slicing the low bits gives the
    // modulo-IM_WORDS index for any pc, in range or not.
    assign offset   = pc - PC_RESET;
    assign im_index = offset[IM_ADDR_W+1:2];

    // Byte-offset and high bits are not part of the index.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{offset[31:IM_ADDR_W+2], offset[1:0]};

`ifdef FETCH_FAULT_EN
    localparam logic [32:0] LIMIT = im_limit(PC_RESET, IM_WORDS);

    logic in_range;
    assign in_range = ({1'b0, pc} >= {1'b0, PC_RESET}) && ({1'b0, pc} < LIMIT);
    assign pc_ok    = in_range && (pc[1:0] == 2'b00);
`else
    assign pc_ok = 1'b1;
`endif

endmodule

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Owns the program counter and qualifies each IM word as a real fetch.
// Arbitrates sequential PC+4, branch/jump redirects and hazard stalls.
//
// Ports:
//   clk             in   1          rising-edge clock
//   reset           in   1          synchronous, active-high
//   stall           in   1          hazard freeze: pc holds, no fetch
//   redirect_valid  in   1          branch/jump taken this cycle
//   redirect_pc     in   32         redirect target
//   pc              out  32         current fetch address (to IM)
//   im_index        out  IM_ADDR_W  IM word index of pc
//   fetch_valid     out  1          IM word at pc is accepted this cycle
//   fault           out  1          sticky fetch-address fault
//   fault_pc        out  32         pc that raised the fault
//   fetch_count     out  32         accepted fetches since reset (wraps)
//
// Build option: FETCH_FAULT_EN enables the address range check and the
// FAULT state. Without it, fault/fault_pc are constant 0 and every pc is
// fetchable (index wraps modulo IM_WORDS).
//
// States: BOOT (one idle cycle after reset) -> RUN -> FAULT (reset only).
// ---------------------------------------------------------------------------
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = DEF_PC_RESET,
    parameter int          IM_WORDS  = DEF_IM_WORDS,
    localparam int         IM_ADDR_W = $clog2(IM_WORDS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    output logic [31:0]          pc,
    output logic [IM_ADDR_W-1:0] im_index,
    output logic                 fetch_valid,
    output logic                 fault,
    output logic [31:0]          fault_pc,
    output logic [31:0]          fetch_count
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  fetch_count_reg;
    logic         pc_ok;

    pc_range_check #(
        .PC_RESET (PC_RESET),
        .IM_WORDS (IM_WORDS)
    ) u_range (
        .pc       (pc_reg),
        .im_index (im_index),
        .pc_ok    (pc_ok)
    );

    // A word is only a fetch in RUN, with no freeze, no squash and a legal pc.
    assign fetch_valid = (state_reg == ST_RUN) && !stall && !redirect_valid && pc_ok;

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        case (state_reg)
            ST_BOOT: begin
                // One idle cycle; stall/redirect deliberately ignored.
                state_next = ST_RUN;
            end
            ST_RUN: begin
`ifdef FETCH_FAULT_EN
                // An illegal pc wins over everything: freeze it for fault_pc.
                if (!pc_ok) begin
                    state_next = ST_FAULT;
                end else
`endif
                // Redirect beats stall so a taken branch is never lost while
                // the pipeline is frozen; the current word is squashed.
                if (redirect_valid) begin
                    pc_next = redirect_pc;
                end else if (!stall && pc_ok) begin
                    pc_next = pc_reg + 32'd4;
                end
            end
`ifdef FETCH_FAULT_EN
            ST_FAULT: begin
                state_next = ST_FAULT;
            end
`endif
            default: begin
                // Unused encoding: restart cleanly from the boot cycle.
                state_next = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_BOOT;
            pc_reg          <= PC_RESET;
            fetch_count_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            if (fetch_valid) begin
                fetch_count_reg <= fetch_count_reg + 32'd1;
            end
        end
    end

`ifdef FETCH_FAULT_EN
    logic        fault_reg;
    logic [31:0] fault_pc_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            fault_reg    <= 1'b0;
            fault_pc_reg <= 32'd0;
        end else if (state_reg == ST_RUN && !pc_ok) begin
            fault_reg    <= 1'b1;
            fault_pc_reg <= pc_reg;
        end
    end

    assign fault    = fault_reg;
    assign fault_pc = fault_pc_reg;
`else
    assign fault    = 1'b0;
    assign fault_pc = 32'd0;
`endif

    assign pc          = pc_reg;
    assign fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Each drive() applies one cycle of inputs and queues the pc / fetch_valid /
// fetch_count expected during that cycle; a negedge monitor pops and checks.
// Scenario tasks add their own inline checks for reset, fault and index.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic [11:0] im_index;
    logic        fetch_valid;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic        fv;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] exp_count;

    fetch_sequencer #(
        .PC_RESET (32'h0000_3000),
        .IM_WORDS (4096)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc),
        .im_index       (im_index),
        .fetch_valid    (fetch_valid),
        .fault          (fault),
        .fault_pc       (fault_pc),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: one expectation per driven cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_checks++;
            if (pc !== e.pc || fetch_valid !== e.fv || fetch_count !== e.cnt) begin
                n_errors++;
                $display("FAIL cycle pc=%h fv=%0b cnt=%0d expected pc=%h fv=%0b cnt=%0d",
                         pc, fetch_valid, fetch_count, e.pc, e.fv, e.cnt);
            end else begin
                $display("ok   cycle pc=%h fv=%0b cnt=%0d", pc, fetch_valid, fetch_count);
            end
        end
    end

    // Apply one cycle of inputs (starting just after a rising edge) and queue
    // what the DUT must present during that cycle.
    task automatic drive(input logic s, input logic rv, input logic [31:0] rpc,
                         input logic [31:0] epc, input logic efv);
        exp_t e;
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rpc;
        e.pc  = epc;
        e.fv  = efv;
        e.cnt = exp_count;
        sb_q.push_back(e);
        if (efv) exp_count = exp_count + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        reset          = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (pc !== 32'h3000 || fetch_valid !== 1'b0 || fault !== 1'b0 ||
            fault_pc !== 32'd0 || fetch_count !== 32'd0 || im_index !== 12'h000) begin
            n_errors++;
            $display("FAIL reset pc=%h fv=%0b fault=%0b fault_pc=%h cnt=%0d idx=%h expected 3000/0/0/0/0/000",
                     pc, fetch_valid, fault, fault_pc, fetch_count, im_index);
        end else begin
            $display("ok   reset pc=%h cnt=%0d", pc, fetch_count);
        end
        reset     = 1'b0;
        exp_count = 32'd0;
    endtask

    task automatic test_sequential();
        test_reset();
        drive(0, 0, 0, 32'h3000, 0);                    // BOOT cycle
        for (int i = 0; i < 20; i++)
            drive(0, 0, 0, 32'h3000 + 32'(4 * i), 1);
        n_checks++;
        if (fetch_count !== 32'd20 || pc !== 32'h3050) begin
            n_errors++;
            $display("FAIL seq_end cnt=%0d pc=%h expected cnt=20 pc=00003050", fetch_count, pc);
        end else begin
            $display("ok   seq_end cnt=%0d pc=%h", fetch_count, pc);
        end
    endtask

    task automatic test_stall();
        test_reset();
        drive(0, 0, 0, 32'h3000, 0);
        for (int i = 0; i < 4; i++)
            drive(0, 0, 0, 32'h3000 + 32'(4 * i), 1);
        for (int i = 0; i < 3; i++)
            drive(1, 0, 0, 32'h3010, 0);
        drive(0, 0, 0, 32'h3010, 1);
        drive(0, 0, 0, 32'h3014, 1);
    endtask

    task automatic test_redirect_stall();
        // pc is 0x3018 here
        drive(1, 1, 32'h3500, 32'h3018, 0);
        drive(1, 0, 0,        32'h3500, 0);
        drive(0, 0, 0,        32'h3500, 1);
        drive(0, 0, 0,        32'h3504, 1);
    endtask

    task automatic test_redirect();
        drive(0, 1, 32'h3100, 32'h3508, 0);
        drive(0, 0, 0,        32'h3100, 1);
        drive(0, 0, 0,        32'h3104, 1);
    endtask

    task automatic test_reset_mid_stall();
        drive(1, 0, 0, 32'h3108, 0);
        stall = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (pc !== 32'h3000 || fetch_count !== 32'd0 || fetch_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_stall pc=%h cnt=%0d fv=%0b expected 3000/0/0",
                     pc, fetch_count, fetch_valid);
        end else begin
            $display("ok   reset_mid_stall pc=%h cnt=%0d", pc, fetch_count);
        end
        reset     = 1'b0;
        exp_count = 32'd0;
        drive(1, 0, 0, 32'h3000, 0);                    // BOOT ignores stall
        drive(0, 0, 0, 32'h3000, 1);
    endtask

`ifndef FETCH_FAULT_EN
    task automatic test_wrap();
        test_reset();
        drive(0, 0, 0, 32'h3000, 0);
        drive(0, 1, 32'hFFFF_FFFC, 32'h3000, 0);
        drive(0, 0, 0, 32'hFFFF_FFFC, 1);
        drive(0, 0, 0, 32'h0000_0000, 1);
        drive(0, 0, 0, 32'h0000_0004, 1);
        stall = 1'b1;
        #1;
        n_checks++;
        // (0x8 - 0x3000) >> 2 = 0x3FFFF402 -> low 12 bits 0x402
        if (pc !== 32'h8 || im_index !== 12'h402) begin
            n_errors++;
            $display("FAIL wrap_index pc=%h idx=%h expected pc=00000008 idx=402", pc, im_index);
        end else begin
            $display("ok   wrap_index pc=%h idx=%h", pc, im_index);
        end
        drive(1, 0, 0, 32'h8, 0);
    endtask
`endif

    task automatic test_far_redirect();
        test_reset();
        drive(0, 0, 0, 32'h3000, 0);
        drive(0, 1, 32'h0010_8000, 32'h3000, 0);
`ifdef FETCH_FAULT_EN
        drive(0, 0, 0, 32'h0010_8000, 0);               // out of range: no fetch
        n_checks++;
        if (fault !== 1'b1 || fault_pc !== 32'h0010_8000) begin
            n_errors++;
            $display("FAIL fault_set fault=%0b fault_pc=%h expected 1/00108000", fault, fault_pc);
        end else begin
            $display("ok   fault_set fault_pc=%h", fault_pc);
        end
        drive(0, 0, 0,        32'h0010_8000, 0);
        drive(0, 1, 32'h3000, 32'h0010_8000, 0);        // redirect ignored in FAULT
        drive(0, 0, 0,        32'h0010_8000, 0);
        n_checks++;
        if (fault !== 1'b1 || pc !== 32'h0010_8000) begin
            n_errors++;
            $display("FAIL fault_hold fault=%0b pc=%h expected 1/00108000", fault, pc);
        end else begin
            $display("ok   fault_hold pc=%h", pc);
        end
`else
        stall          = 1'b0;
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (im_index !== 12'h400 || fault !== 1'b0 || fetch_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL far_index idx=%h fault=%0b fv=%0b expected 400/0/1",
                     im_index, fault, fetch_valid);
        end else begin
            $display("ok   far_index idx=%h", im_index);
        end
        drive(0, 0, 0, 32'h0010_8000, 1);
        drive(0, 0, 0, 32'h0010_8004, 1);
`endif
    endtask

    initial begin
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        exp_count      = 32'd0;

        test_reset();
        test_sequential();
        test_stall();
        test_redirect_stall();
        test_redirect();
        test_reset_mid_stall();
`ifndef FETCH_FAULT_EN
        test_wrap();
`endif
        test_far_redirect();
        test_reset();                                   // leaves FAULT when enabled

        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain left=%0d expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch sequencer for the single-cycle/pipelined MIPS core: owns the program counter, presents it to IM, and decides each cycle whether the word IM returns is a valid fetch. It arbitrates between the sequential PC+4 path, redirects from branch/jump resolution, and stalls from the hazard unit. It sits between the NPC/hazard logic and IM, replacing the bare PC register.

## Interface
Parameters:
- PC_RESET, 32'h0000_3000, reset vector and IM base address
- IM_WORDS, 4096, IM depth in 32-bit words (power of two)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard unit freeze; PC holds, no fetch accepted
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  32  target address for redirect
- pc  out  32  current fetch address, drives IM PC input
- im_index  out  log2(IM_WORDS)  word index (pc - PC_RESET) >> 2
- fetch_valid  out  1  IM word at pc is a real fetch this cycle
- fault  out  1  sticky fetch-address fault
- fault_pc  out  32  pc that caused the fault
- fetch_count  out  32  number of accepted fetches since reset

## Operation
- States: BOOT, RUN, FAULT.
- Reset: pc = PC_RESET, state = BOOT, fetch_valid = 0, fault = 0, fault_pc = 0, fetch_count = 0.
- BOOT: fetch_valid = 0, pc held; next edge -> RUN unconditionally (stall/redirect ignored).
- RUN: fetch_valid = ~stall & ~redirect_valid & pc_ok (pc_ok = in range and word-aligned; always 1 without macro).
- PC update priority in RUN: redirect_valid -> pc <= redirect_pc (even when stall = 1; squashes current word); else stall -> hold; else pc_ok -> pc <= pc + 4.
- pc + 4 is 32-bit, wraps mod 2^32.
- fetch_count increments by 1 on each edge where fetch_valid = 1; wraps at 2^32.
- FAULT: fetch_valid = 0, pc frozen, fault = 1; exit only via reset.
- Simultaneous redirect_valid and stall: redirect wins, fetch_valid = 0.
- Reset asserted in any state (including mid-stall or FAULT) returns to reset values on that edge.

## Timing
- pc, state, counters are registers; fetch_valid and im_index are combinational from registered pc/state and current inputs.
- IM is combinational: Instr valid same cycle as pc; consumer latches Instr on the edge where fetch_valid = 1.
- First valid fetch: second cycle after reset deasserts (one BOOT cycle), at pc = PC_RESET.
- Redirect latency: target fetched in the cycle after redirect_valid is sampled.
- Fault detect: pc_ok = 0 in RUN -> same cycle fetch_valid = 0; next edge state = FAULT, fault_pc <= pc, fault = 1.

## Configuration
- FETCH_FAULT_EN defined: range check active; valid range PC_RESET <= pc < PC_RESET + 4*IM_WORDS, pc[1:0] = 0; violation enters FAULT.
- Not defined: no FAULT state; im_index = (pc - PC_RESET)[log2(IM_WORDS)+1:2] wraps modulo IM_WORDS, pc[1:0] ignored; fault and fault_pc tied 0.

## Structure
- Shared package fetch_pkg: state enum (BOOT, RUN, FAULT), default PC_RESET, IM_WORDS, derived IM_ADDR_W and IM_LIMIT constants.
- One sub-module: pc_range_check (combinational; pc in -> im_index, pc_ok out), reused by later cached/multi-bank IM.

## Test plan
- Reset release, no stall/redirect, 20 cycles -> cycle 1 fetch_valid = 0, then pc = 0x3000, 0x3004, ... 0x304C with fetch_valid = 1; fetch_count = 20.
- stall = 1 for 3 cycles at pc = 0x3010 -> pc holds 0x3010, fetch_valid = 0, count unchanged; after release next pc 0x3014.
- redirect_valid = 1, redirect_pc = 0x3500 with stall = 1 -> fetch_valid = 0 that cycle, next pc = 0x3500, fetch valid there once stall drops.
- FETCH_FAULT_EN: redirect to 0x0010_8000 -> next cycle fetch_valid = 0, following edge fault = 1, fault_pc = 0x0010_8000, pc frozen until reset.
- Without FETCH_FAULT_EN: same redirect -> no fault, im_index = 0x400 wrapped modulo 4096 (i.e. (0x108000-0x3000)>>2 mod 4096), fetch_valid = 1.
- reset asserted in FAULT or mid-stall -> next cycle pc = 0x3000, state BOOT, fault = 0, fetch_count = 0.
